instr_fetch_stage: RTL and testbench

- Fetch stage that sits directly upstream of ProgramMemory and downstream-feeds the decode stage.
- Owns the PC register and drives the word address into the combinational instruction memory.
- Captures the returned opcode together with its PC into a small FIFO and presents entries to decode with a valid/ready handshake.
- Accepts redirects (jump/branch/JAL targets) from execute and flushes wrong-path entries.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_stage.sv | 82 ++++++++
 tb/tb_instr_fetch_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : shared fetch-path types and constants        rev 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int INSTR_W    = 32;

  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;
  localparam logic [INSTR_W-1:0]    NOP_INSTR    = 32'h0;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_fifo : small synchronous FIFO with flush; dout reads zero when empty
// rev 1.0
// ---------------------------------------------------------------------------
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type ENTRY_T = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  ENTRY_T           din,
  output ENTRY_T           dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  ENTRY_T           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (count <= CNT_W'(DEPTH));
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_stage : PC register, imem addressing, fetch buffer to decode
// rev 1.0
// ---------------------------------------------------------------------------
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(CPU_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_LIMIT   = ADDR_W'(2048),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk_signal,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               dec_ready,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic               fetch_idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              in_range;
  logic              deq;
  logic              enq;
  entry_t            fetch_in;
  entry_t            head;

  assign imem_addr  = pc_q;
  assign in_range   = (pc_q <= PC_LIMIT);
  assign dec_valid  = (fifo_count != '0);
  assign deq        = dec_valid & dec_ready;
  // Redirect wins: the word at pc_q in a redirect cycle is wrong-path.
  assign enq        = ~redirect_valid & in_range & (~fifo_full | deq);
  assign fetch_in   = '{pc: pc_q, instr: imem_data};
  assign dec_pc     = head.pc;
  assign dec_instr  = head.instr;
  assign fetch_idle = ~in_range & fifo_empty;

  always_ff @(posedge clk_signal or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (enq) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .ENTRY_T (entry_t)
  ) u_fetch_fifo (
    .clk   (clk_signal),
    .rst_n (reset_n),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (fetch_in),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_fetch_stage : queue-based reference model plus directed scenarios
// rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_fetch_stage;

  localparam logic [31:0] LIMIT = 32'd8;
  localparam int          DEPTH = 2;

  logic        clk_signal = 1'b0;
  logic        reset_n    = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_idle;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_signal = ~clk_signal;

  instr_fetch_stage #(
    .ADDR_W     (32),
    .RESET_PC   (32'd0),
    .PC_LIMIT   (LIMIT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_signal     (clk_signal),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_idle     (fetch_idle)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0000;
      32'd1:   return 32'h0842_0032;
      32'd2:   return 32'h0884_0032;
      32'd3:   return 32'h1046_2000;
      default: return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
    endcase
  endfunction

  assign imem_data = memword(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending entries as a queue of {pc, instr}, plus the PC.
  logic [63:0] mq[$];
  logic [31:0] mpc;

  task automatic model_reset();
    mq.delete();
    mpc = 32'd0;
  endtask

  task automatic model_step();
    bit take;
    bit fetch;
    take = (mq.size() != 0) && dec_ready;
    if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc;
    end else begin
      fetch = (mpc <= LIMIT) && ((mq.size() < DEPTH) || take);
      if (take) void'(mq.pop_front());
      if (fetch) begin
        mq.push_back({mpc, memword(mpc)});
        mpc = mpc + 32'd1;
      end
    end
  endtask

  always @(negedge clk_signal) begin
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    if (!reset_n) model_reset();
    ev  = (mq.size() != 0);
    epc = ev ? mq[0][63:32] : 32'd0;
    ein = ev ? mq[0][31:0]  : 32'd0;
    check("m_dec_valid",  {63'd0, dec_valid}, {63'd0, ev});
    check("m_dec_pc",     {32'd0, dec_pc},    {32'd0, epc});
    check("m_dec_instr",  {32'd0, dec_instr}, {32'd0, ein});
    check("m_imem_addr",  {32'd0, imem_addr}, {32'd0, mpc});
    check("m_fetch_idle", {63'd0, fetch_idle}, {63'd0, (mpc > LIMIT) && !ev});
    if (reset_n) model_step();
  end

  task automatic tick();
    @(posedge clk_signal);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_signal);
    #1;
  endtask

  logic [31:0] prog [4];
  bit          found;

  initial begin
    prog = '{32'h0000_0000, 32'h0842_0032, 32'h0884_0032, 32'h1046_2000};
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_dec_valid",  {63'd0, dec_valid}, 64'd0);
    check("rst_dec_pc",     {32'd0, dec_pc},    64'd0);
    check("rst_imem_addr",  {32'd0, imem_addr}, 64'd0);
    check("rst_fetch_idle", {63'd0, fetch_idle}, 64'd0);
    repeat (3) @(posedge clk_signal);
    #1 reset_n = 1'b1;

    // Streaming straight out of reset
    mid();
    check("stream_c0_valid", {63'd0, dec_valid}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      mid();
      check("stream_valid", {63'd0, dec_valid}, 64'd1);
      check("stream_pc",    {32'd0, dec_pc},    k);
      check("stream_instr", {32'd0, dec_instr}, {32'd0, prog[k]});
    end

    // Backpressure from a fresh reset
    tick();
    dec_ready = 1'b0;
    reset_n   = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("bp_hold_valid", {63'd0, dec_valid}, 64'd1);
    check("bp_hold_pc",    {32'd0, dec_pc},    64'd0);
    check("bp_hold_addr",  {32'd0, imem_addr}, 64'd2);
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("bp_release_pc",   {32'd0, dec_pc},    k);
      check("full_deq_addr",   {32'd0, imem_addr}, 2 + k);
    end

    // Redirect with two entries queued and the head being consumed
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_addr == 32'd7) found = 1'b1;
    end
    check("wait_pc7", {63'd0, found}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd1;
    mid();
    check("redir_head_pc", {32'd0, dec_pc}, 64'd5);
    tick();
    redirect_valid = 1'b0;
    check("redir_gap_valid", {63'd0, dec_valid}, 64'd0);
    check("redir_addr",      {32'd0, imem_addr}, 64'd1);
    tick();
    check("redir_target_pc",    {32'd0, dec_pc},    64'd1);
    check("redir_target_instr", {32'd0, dec_instr}, 64'h0842_0032);

    // Run into the fetch limit
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (fetch_idle) found = 1'b1;
    end
    check("limit_idle_seen", {63'd0, found}, 64'd1);
    repeat (2) tick();
    check("limit_addr_held", {32'd0, imem_addr},  64'd9);
    check("limit_idle",      {63'd0, fetch_idle}, 64'd1);
    check("limit_no_valid",  {63'd0, dec_valid},  64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    tick();
    redirect_valid = 1'b0;
    check("resume_idle", {63'd0, fetch_idle}, 64'd0);
    check("resume_addr", {32'd0, imem_addr},  64'd0);
    tick();
    check("resume_pc", {32'd0, dec_pc}, 64'd0);

    // Redirect beyond the limit leaves the stage idle
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd100;
    tick();
    redirect_valid = 1'b0;
    check("far_addr",  {32'd0, imem_addr},  64'd100);
    check("far_valid", {63'd0, dec_valid},  64'd0);
    check("far_idle",  {63'd0, fetch_idle}, 64'd1);

    // Back-to-back redirects: the later one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'd3;
    tick();
    redirect_pc    = 32'd5;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("b2b_pc",    {32'd0, dec_pc},    64'd5);
    check("b2b_instr", {32'd0, dec_instr}, 64'hC0DE_0005);

    // Asynchronous reset between edges with a full buffer
    dec_ready = 1'b0;
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    check("areset_valid", {63'd0, dec_valid}, 64'd0);
    check("areset_pc",    {32'd0, dec_pc},    64'd0);
    check("areset_addr",  {32'd0, imem_addr}, 64'd0);
    tick();
    reset_n   = 1'b1;
    dec_ready = 1'b1;
    mid();
    check("areset_c0_valid", {63'd0, dec_valid}, 64'd0);
    mid();
    check("areset_restart_valid", {63'd0, dec_valid}, 64'd1);
    check("areset_restart_pc",    {32'd0, dec_pc},    64'd0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
`default_nettype wire
